// File: rtl/row_split_mdl.sv
// Matrix-to-row serializer: captures one flattened matrix and replays it one
// vector per accepted cycle, flagging the last vector with dendFlag.
module row_split_mdl #(
   parameter int DATA_SIZE   = 16,
   parameter int COLUMN_SIZE = 8,
   parameter int ROW_SIZE    = 8,
   localparam int VEC_W = DATA_SIZE * ROW_SIZE,
   localparam int MAT_W = VEC_W * COLUMN_SIZE,
   localparam int CNT_W = $clog2(COLUMN_SIZE) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dsetFlag,
   input  logic [MAT_W-1:0] datsIn,
   output logic             loadReady,
   input  logic             enable,
   output logic [VEC_W-1:0] dats,
   output logic             dvalidFlag,
   output logic             dendFlag,
   output logic             dbg_state
);

   // Handshakes: a matrix moves when dsetFlag && loadReady; a vector moves when
   // dvalidFlag && enable. The producer holds dsetFlag/datsIn until loadReady.
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COLUMN_SIZE - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] next_count;
   logic [MAT_W-1:0] mat_q;

   assign next_count = count + 1'b1;
   assign loadReady  = (state == IDLE) || ((state == SEND) && enable && dendFlag);
   assign dbg_state  = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         mat_q      <= '0;
         dats       <= '0;
         dvalidFlag <= 1'b0;
         dendFlag   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dsetFlag) begin
                  mat_q      <= datsIn;
                  count      <= '0;
                  dats       <= datsIn[VEC_W-1:0];
                  dvalidFlag <= 1'b1;
                  dendFlag   <= (COLUMN_SIZE == 1);
                  state      <= SEND;
               end
            end
            SEND: begin
               if (enable) begin
                  if (count == LAST) begin
                     count <= '0;
                     // A new matrix captured on the last beat follows with no bubble.
                     if (dsetFlag) begin
                        mat_q      <= datsIn;
                        dats       <= datsIn[VEC_W-1:0];
                        dvalidFlag <= 1'b1;
                        dendFlag   <= (COLUMN_SIZE == 1);
                     end else begin
                        dats       <= '0;
                        dvalidFlag <= 1'b0;
                        dendFlag   <= 1'b0;
                        state      <= IDLE;
                     end
                  end else begin
                     count    <= next_count;
                     dats     <= mat_q[next_count*VEC_W +: VEC_W];
                     dendFlag <= (next_count == LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
